// File: rtl/perf_burst_sequencer_if.sv
// AXI4 bus bundle between the burst sequencer and the PCIe/DDR datapath.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready and its payload stays put until taken.
interface axi4_bus_t #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [63:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/perf_burst_sequencer.sv
// Write-then-read AXI4 burst traffic generator with pattern check, error and busy-cycle counters.
// One burst outstanding at a time; beat data is (pattern + beat number) replicated over the bus.
module perf_burst_sequencer #(
  parameter int BEAT_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      start_addr,
  input  logic [7:0]       burst_len,
  input  logic [15:0]      num_bursts,
  input  logic [1:0]       mode,
  input  logic [31:0]      pattern,
  output logic             busy,
  output logic [1:0]       rw_done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycles,
  output logic [2:0]       dbg_state,
  axi4_bus_t.master        axi
);
  localparam int DATA_W = BEAT_BYTES * 8;
  localparam int LANES  = DATA_W / 32;
  localparam logic [2:0] SIZE = 3'($clog2(BEAT_BYTES));

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t state, state_next;

  logic [63:0] base_addr, cur_addr, addr_step;
  logic [7:0]  len, beat_idx;
  logic [15:0] nbursts, burst_idx;
  logic [1:0]  run_mode;
  logic [31:0] seed, beat_data;
  logic        accept, last_burst, r_beat, r_bad, early_last;
  logic [1:0]  err_inc;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_next;
  logic        unused_ids;

  assign accept     = (state == IDLE) && start && (mode != 2'b00);
  assign last_burst = (burst_idx == nbursts - 16'd1);
  assign r_beat     = (state == RD_DATA) && axi.rvalid;
  assign addr_step  = ({56'd0, len} + 64'd1) << SIZE;
  assign unused_ids = ^{axi.bid, axi.rid};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) begin
                 if (num_bursts == 16'd0) state_next = DONE;
                 else if (mode[0])        state_next = WR_ADDR;
                 else                     state_next = RD_ADDR;
               end
      WR_ADDR: if (axi.awready) state_next = WR_DATA;
      WR_DATA: if (axi.wready && beat_idx == len) state_next = WR_RESP;
      WR_RESP: if (axi.bvalid) begin
                 if (!last_burst)      state_next = WR_ADDR;
                 else if (run_mode[1]) state_next = RD_ADDR;
                 else                  state_next = DONE;
               end
      RD_ADDR: if (axi.arready) state_next = RD_DATA;
      RD_DATA: if (axi.rvalid && axi.rlast) state_next = last_burst ? DONE : RD_ADDR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A beat with bad data and/or bad rresp is one error; a misplaced rlast adds one more.
  always_comb begin
    r_bad      = 1'b0;
    early_last = 1'b0;
    err_inc    = 2'd0;
    if (state == WR_RESP && axi.bvalid && axi.bresp != 2'b00) err_inc = 2'd1;
    if (r_beat) begin
      r_bad      = (axi.rdata != {LANES{beat_data}}) || (axi.rresp != 2'b00);
      early_last = axi.rlast && (beat_idx != len);
      err_inc    = {1'b0, r_bad} + {1'b0, early_last};
    end
    err_sum  = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, err_inc};
    err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_addr <= '0;
      cur_addr  <= '0;
      len       <= '0;
      nbursts   <= '0;
      run_mode  <= '0;
      seed      <= '0;
      beat_data <= '0;
      beat_idx  <= '0;
      burst_idx <= '0;
      rw_done   <= '0;
      err_cnt   <= '0;
      cycles    <= '0;
    end else if (accept) begin
      base_addr <= start_addr;
      cur_addr  <= start_addr;
      len       <= burst_len;
      nbursts   <= num_bursts;
      run_mode  <= mode;
      seed      <= pattern;
      beat_data <= pattern;
      beat_idx  <= '0;
      burst_idx <= '0;
      rw_done   <= (num_bursts == 16'd0) ? mode : 2'b00;
      err_cnt   <= '0;
      cycles    <= '0;
    end else begin
      if (state != IDLE && cycles != '1) cycles <= cycles + CNT_W'(1);
      err_cnt <= err_next;
      case (state)
        WR_DATA: if (axi.wready) begin
                   beat_data <= beat_data + 32'd1;
                   beat_idx  <= (beat_idx == len) ? 8'd0 : beat_idx + 8'd1;
                 end
        WR_RESP: if (axi.bvalid) begin
                   if (last_burst) begin
                     rw_done[0] <= 1'b1;
                     burst_idx  <= '0;
                     cur_addr   <= base_addr;
                     beat_data  <= seed;
                   end else begin
                     burst_idx <= burst_idx + 16'd1;
                     cur_addr  <= cur_addr + addr_step;
                   end
                 end
        RD_DATA: if (axi.rvalid) begin
                   beat_data <= beat_data + 32'd1;
                   if (axi.rlast) begin
                     beat_idx <= '0;
                     if (last_burst) rw_done[1] <= 1'b1;
                     else begin
                       burst_idx <= burst_idx + 16'd1;
                       cur_addr  <= cur_addr + addr_step;
                     end
                   end else begin
                     beat_idx <= beat_idx + 8'd1;
                   end
                 end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign axi.awid    = '0;
  assign axi.awaddr  = cur_addr;
  assign axi.awlen   = len;
  assign axi.awsize  = SIZE;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (state == WR_ADDR);
  assign axi.wdata   = {LANES{beat_data}};
  assign axi.wstrb   = '1;
  assign axi.wlast   = (state == WR_DATA) && (beat_idx == len);
  assign axi.wvalid  = (state == WR_DATA);
  assign axi.bready  = (state == WR_RESP);
  assign axi.arid    = '0;
  assign axi.araddr  = cur_addr;
  assign axi.arlen   = len;
  assign axi.arsize  = SIZE;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state == RD_ADDR);
  assign axi.rready  = (state == RD_DATA);
endmodule

// File: tb/tb_perf_burst_sequencer.sv
// Bench for perf_burst_sequencer: randomized AXI slave with stalls and fault injection,
// expected traffic and error counts derived from the address/data/error rules of a run.
module tb_perf_burst_sequencer;
  localparam int BEAT_BYTES = 64;
  localparam int CNT_W      = 32;
  localparam int DW         = BEAT_BYTES * 8;
  localparam int LANES      = DW / 32;
  localparam logic [2:0] SIZE = 3'($clog2(BEAT_BYTES));
  localparam int BUDGET     = 5000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [63:0]      start_addr = '0;
  logic [7:0]       burst_len = '0;
  logic [15:0]      num_bursts = '0;
  logic [1:0]       mode = '0;
  logic [31:0]      pattern = '0;
  logic             busy;
  logic [1:0]       rw_done;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] cycles;
  logic [2:0]       dbg_state;

  axi4_bus_t #(.DATA_W(DW)) axi_bus ();

  perf_burst_sequencer #(.BEAT_BYTES(BEAT_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .mode(mode), .pattern(pattern),
    .busy(busy), .rw_done(rw_done), .err_cnt(err_cnt), .cycles(cycles),
    .dbg_state(dbg_state), .axi(axi_bus)
  );

  // scoreboard
  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_ar_q[$];
  logic [31:0] exp_w_q[$];
  logic        exp_last_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave knobs and state
  int stall_pct = 0;
  int corrupt_beat = -1;
  int rresp_beat = -1;
  int bresp_burst = -1;
  logic [31:0] cfg_pattern = '0;
  logic [7:0]  cfg_len = '0;
  bit b_fire, r_fire, pend_b, r_active, aw_hold, w_hold, ar_hold;
  int b_idx = 0, r_local = 0, r_glob = 0, wlast_cnt = 0;
  logic [63:0]   aw_prev, ar_prev;
  logic [DW-1:0] w_prev;
  logic          wl_prev;
  logic [31:0]   w_exp_v, r_val;
  logic          l_exp_v;

  function automatic bit go();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  // Slave: decides ready/valid at negedge, so handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.arready = 0;
      axi_bus.bvalid = 0; axi_bus.bresp = 0; axi_bus.bid = 0;
      axi_bus.rvalid = 0; axi_bus.rdata = '0; axi_bus.rresp = 0; axi_bus.rlast = 0; axi_bus.rid = 0;
      b_fire = 0; r_fire = 0; pend_b = 0; r_active = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      if (aw_hold) check("aw_stable", {axi_bus.awvalid, axi_bus.awaddr}, {1'b1, aw_prev});
      if (ar_hold) check("ar_stable", {axi_bus.arvalid, axi_bus.araddr}, {1'b1, ar_prev});
      if (w_hold) begin
        check("w_stable_data", axi_bus.wdata, w_prev);
        check("w_stable_ctl", {axi_bus.wvalid, axi_bus.wlast}, {1'b1, wl_prev});
      end
      if (b_fire) axi_bus.bvalid = 0;
      if (r_fire) begin
        axi_bus.rvalid = 0;
        axi_bus.rlast = 0;
        r_glob++;
        if (r_local == int'(cfg_len)) r_active = 0;
        else r_local++;
      end
      axi_bus.awready = go();
      axi_bus.wready  = go();
      axi_bus.arready = go();
      if (pend_b && !axi_bus.bvalid && go()) begin
        axi_bus.bvalid = 1;
        axi_bus.bresp = (b_idx == bresp_burst) ? 2'd2 : 2'd0;
        pend_b = 0;
        b_idx++;
      end
      if (r_active && !axi_bus.rvalid && go()) begin
        r_val = cfg_pattern + 32'(r_glob);
        axi_bus.rvalid = 1;
        axi_bus.rdata = (r_glob == corrupt_beat) ? '0 : {LANES{r_val}};
        axi_bus.rresp = (r_glob == rresp_beat) ? 2'd3 : 2'd0;
        axi_bus.rlast = (r_local == int'(cfg_len));
      end
      if (axi_bus.awvalid && axi_bus.awready) begin
        if (exp_aw_q.size() == 0) check("aw_extra", 1, 0);
        else check("aw_addr", axi_bus.awaddr, exp_aw_q.pop_front());
        check("aw_fields", {axi_bus.awid, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst},
              {4'd0, cfg_len, SIZE, 2'b01});
      end
      if (axi_bus.arvalid && axi_bus.arready) begin
        if (exp_ar_q.size() == 0) check("ar_extra", 1, 0);
        else check("ar_addr", axi_bus.araddr, exp_ar_q.pop_front());
        check("ar_fields", {axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst},
              {4'd0, cfg_len, SIZE, 2'b01});
        r_active = 1;
        r_local = 0;
      end
      if (axi_bus.wvalid && axi_bus.wready) begin
        if (exp_w_q.size() == 0) check("w_extra", 1, 0);
        else begin
          w_exp_v = exp_w_q.pop_front();
          l_exp_v = exp_last_q.pop_front();
          check("w_data", axi_bus.wdata, {LANES{w_exp_v}});
          check("w_last", axi_bus.wlast, l_exp_v);
        end
        check("w_strb", axi_bus.wstrb, {(DW/8){1'b1}});
        if (axi_bus.wlast) begin
          wlast_cnt++;
          pend_b = 1;
        end
      end
      aw_hold = axi_bus.awvalid && !axi_bus.awready; aw_prev = axi_bus.awaddr;
      ar_hold = axi_bus.arvalid && !axi_bus.arready; ar_prev = axi_bus.araddr;
      w_hold  = axi_bus.wvalid && !axi_bus.wready;   w_prev = axi_bus.wdata; wl_prev = axi_bus.wlast;
      b_fire = axi_bus.bvalid && axi_bus.bready;
      r_fire = axi_bus.rvalid && axi_bus.rready;
    end
  end

  // Reference model: fills expected traffic and returns the expected error count.
  function automatic int load_model(input logic [63:0] a, input logic [7:0] l, input logic [15:0] nb,
                                    input logic [1:0] m, input logic [31:0] p);
    int beats = int'(nb) * (int'(l) + 1);
    int errs = 0;
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_last_q.delete();
    for (int k = 0; k < int'(nb); k++) begin
      if (m[0]) exp_aw_q.push_back(a + 64'(k) * (64'(l) + 64'd1) * 64'(BEAT_BYTES));
      if (m[1]) exp_ar_q.push_back(a + 64'(k) * (64'(l) + 64'd1) * 64'(BEAT_BYTES));
    end
    if (m[0]) begin
      for (int n = 0; n < beats; n++) begin
        exp_w_q.push_back(p + 32'(n));
        exp_last_q.push_back((n % (int'(l) + 1)) == int'(l));
      end
      if (bresp_burst >= 0 && bresp_burst < int'(nb)) errs++;
    end
    if (m[1])
      for (int n = 0; n < beats; n++)
        if ((n == corrupt_beat && (p + 32'(n)) != 32'd0) || n == rresp_beat) errs++;
    cfg_len = l; cfg_pattern = p;
    r_glob = 0; b_idx = 0; wlast_cnt = 0;
    return errs;
  endfunction

  // driver: one full run, optionally pulsing start again while busy
  task automatic run_pass(input string name, input logic [63:0] a, input logic [7:0] l,
                          input logic [15:0] nb, input logic [1:0] m, input logic [31:0] p,
                          input bit poke);
    int exp_err, busy_obs, cyc;
    exp_err = load_model(a, l, nb, m, p);
    @(negedge clk); #1;
    start = 1; start_addr = a; burst_len = l; num_bursts = nb; mode = m; pattern = p;
    @(negedge clk); #1;
    start = 0;
    busy_obs = 0; cyc = 0;
    while (busy && cyc < BUDGET) begin
      busy_obs++;
      if (poke && cyc == 3) begin
        start = 1; mode = 2'b01; num_bursts = 16'd1; start_addr = ~a; pattern = ~p;
      end else start = 0;
      @(negedge clk); #1;
      cyc++;
    end
    start = 0;
    check($sformatf("%s_timeout", name), busy, 0);
    check($sformatf("%s_rw_done", name), rw_done, m);
    check($sformatf("%s_err_cnt", name), err_cnt, exp_err);
    check($sformatf("%s_cycles", name), cycles, busy_obs);
    check($sformatf("%s_aw_left", name), exp_aw_q.size(), 0);
    check($sformatf("%s_w_left", name), exp_w_q.size(), 0);
    check($sformatf("%s_ar_left", name), exp_ar_q.size(), 0);
    check($sformatf("%s_wlast_cnt", name), wlast_cnt, m[0] ? int'(nb) : 0);
    if (nb == 16'd0) check($sformatf("%s_two_cycle", name), busy_obs, 1);
  endtask

  task automatic reset_mid_burst();
    int dummy;
    bit hit, noisy;
    stall_pct = 0;
    dummy = load_model(64'h4000, 8'd7, 16'd2, 2'b01, 32'h55AA0000);
    @(negedge clk); #1;
    start = 1; start_addr = 64'h4000; burst_len = 8'd7; num_bursts = 16'd2; mode = 2'b01;
    pattern = 32'h55AA0000;
    hit = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk); #1;
      start = 0;
      if (axi_bus.wvalid && axi_bus.wdata[31:0] == 32'h55AA0002) begin
        hit = 1;
        break;
      end
    end
    check("rst_mid_reach_beat2", hit, 1);
    rst_n = 0;
    @(negedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_stats", {rw_done, err_cnt, cycles}, 0);
    check("rst_mid_axi", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.wlast, axi_bus.bready,
                          axi_bus.arvalid, axi_bus.rready}, 0);
    rst_n = 1;
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_last_q.delete();
    noisy = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (busy || axi_bus.awvalid || axi_bus.wvalid || axi_bus.arvalid || axi_bus.bready || axi_bus.rready)
        noisy = 1;
    end
    check("rst_mid_quiet", noisy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_stats", {rw_done, err_cnt, cycles}, 0);
    check("reset_axi", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.wlast, axi_bus.bready,
                        axi_bus.arvalid, axi_bus.rready}, 0);
    rst_n = 1;

    stall_pct = 0;
    run_pass("clean", 64'h1000, 8'd3, 16'd4, 2'b11, 32'hA5A50000, 0);

    corrupt_beat = 5;
    run_pass("rd_corrupt", 64'h2000, 8'd3, 16'd4, 2'b10, 32'h12340000, 0);
    corrupt_beat = -1;

    stall_pct = 40;
    for (int i = 0; i < 3; i++)
      run_pass($sformatf("bp%0d", i), {$urandom, $urandom}, 8'($urandom_range(0, 7)),
               16'($urandom_range(1, 6)), 2'b11, $urandom, 0);

    stall_pct = 0;
    bresp_burst = 1; rresp_beat = 6;
    run_pass("resp_err", 64'h8000, 8'd3, 16'd3, 2'b11, 32'hC0DE0000, 0);
    bresp_burst = -1; rresp_beat = -1;

    run_pass("zero_bursts", 64'h9000, 8'd3, 16'd0, 2'b11, 32'h0, 0);

    @(negedge clk); #1;
    start = 1; mode = 2'b00; num_bursts = 16'd2;
    @(negedge clk); #1;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      check("mode00_busy", busy, 0);
      @(negedge clk); #1;
    end
    check("mode00_hold", {rw_done, cycles}, {2'b11, 32'd1});

    stall_pct = 30;
    run_pass("start_busy", 64'hA000, 8'd2, 16'd3, 2'b11, 32'h77770000, 1);

    reset_mid_burst();
    stall_pct = 0;
    run_pass("after_rst", 64'h4000, 8'd7, 16'd2, 2'b11, 32'h55AA0000, 0);

    stall_pct = 25;
    for (int i = 0; i < 4; i++) begin
      corrupt_beat = (i == 2) ? int'($urandom_range(0, 3)) : -1;
      run_pass($sformatf("rnd%0d", i), {$urandom, $urandom}, 8'($urandom_range(0, 5)),
               16'($urandom_range(1, 5)), 2'($urandom_range(1, 3)), $urandom, 0);
    end
    corrupt_beat = -1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/perf_burst_sequencer.md
PERF_BURST_SEQUENCER -- requirements
Module: perf_burst_sequencer

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 64: bytes per AXI4 data beat; fixes awsize/arsize = log2(BEAT_BYTES).
REQ-002 SHALL have parameter CNT_W, default 32: width of err_cnt and cycles.
REQ-003 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle run request.
REQ-006 SHALL have port start_addr  input  64  byte address of the first burst.
REQ-007 SHALL have port burst_len  input  8  AXI len: beats per burst minus 1.
REQ-008 SHALL have port num_bursts  input  16  bursts per phase.
REQ-009 SHALL have port mode  input  2  bit0 enables the write phase, bit1 enables the read phase.
REQ-010 SHALL have port pattern  input  32  data seed.
REQ-011 SHALL have port busy  output  1  high while a run is in progress.
REQ-012 SHALL have port rw_done  output  2  [0] write phase complete, [1] read phase complete.
REQ-013 SHALL have port err_cnt  output  CNT_W  count of data and response errors.
REQ-014 SHALL have port cycles  output  CNT_W  count of busy clock cycles.
REQ-015 SHALL have port axi  axi4_bus_t.master  -  AXI4 master to the PCIe/DDR datapath.

Function
REQ-016 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, with at most one burst outstanding.
REQ-017 SHALL, on start in IDLE with mode!=0:
- latch all configuration inputs;
- clear rw_done, err_cnt and cycles;
- enter WR_ADDR if mode[0]=1, otherwise RD_ADDR.
REQ-018 SHALL ignore start outside IDLE, and SHALL ignore start when mode=00.
REQ-019 SHALL, when num_bursts=0, go IDLE->DONE, set rw_done to the latched mode, and issue no AXI traffic.
REQ-020 SHALL set the address of burst k to start_addr + k*(burst_len+1)*BEAT_BYTES, computed modulo 2^64.
REQ-021 SHALL set the data of global beat n (counted from 0 across bursts, restarting at 0 in each phase) to (pattern+n) mod 2^32, replicated across the data width.
REQ-022 SHALL drive fixed AXI fields: id=0, burst=INCR, size per REQ-001, wstrb all ones.
REQ-023 SHALL raise awvalid/arvalid on the cycle after start (or after the previous burst ends) and hold it with stable payload until the matching ready is sampled high.
REQ-024 SHALL, in WR_DATA:
- hold wvalid high with stable data until wready;
- assert wlast on beat burst_len;
- enter WR_RESP after the last beat is accepted.
REQ-025 SHALL hold bready high in WR_RESP, and on bvalid SHALL increment err_cnt if bresp!=0.
REQ-026 SHALL, after the last write burst's response, set rw_done[0] and go to RD_ADDR if mode[1]=1, else DONE.
REQ-027 SHALL hold rready high in RD_DATA and compare every rvalid beat with the expected pattern.
REQ-028 SHALL increment err_cnt by 1 per beat with a data mismatch, rresp!=0, or both.
REQ-029 SHALL end a read burst on rlast; an rlast on a beat index other than burst_len SHALL add one further error.
REQ-030 SHALL, after the last read burst, set rw_done[1] and enter DONE.
REQ-031 SHALL go DONE->IDLE after one cycle, and rw_done, err_cnt and cycles SHALL hold until the next accepted start.
REQ-032 SHALL assert busy in every state except IDLE.
REQ-033 SHALL increment cycles on every cycle busy is high.
REQ-034 SHALL saturate cycles and err_cnt at all ones instead of wrapping.
REQ-035 SHALL never combinationally depend any valid on a ready.

Reset
REQ-036 SHALL, while rst_n=0 at a clock edge, return to IDLE and zero busy, rw_done, err_cnt, cycles and every AXI valid/ready/last output.
REQ-037 SHALL apply REQ-036 even mid-burst; after such a reset no further beats or responses are issued or tracked.

Verification
REQ-038 Bench SHALL cover a write-then-read clean run: mode=11, num_bursts=4, burst_len=3, start_addr=0x1000, pattern=0xA5A50000, zero-wait slave -> addresses 0x1000/0x1100/0x1200/0x1300, write data values 0xA5A50000..0xA5A5000F, rw_done=11, err_cnt=0.
REQ-039 Bench SHALL cover read-only with a corrupted beat: mode=10, and read beat 5 returned as 0 -> err_cnt=1, rw_done=10.
REQ-040 Bench SHALL cover backpressure: random awready/wready/arready stalls -> payload stable while valid is high, no beat lost or duplicated, wlast count = num_bursts.
REQ-041 Bench SHALL cover error responses: bresp=2 on burst 1 and rresp=3 on a single beat -> err_cnt=2.
REQ-042 Bench SHALL cover the edge cases:
- num_bursts=0 -> DONE in 2 cycles, no AXI valid;
- start while busy -> ignored.
REQ-043 Bench SHALL cover reset mid-burst: rst_n low during WR_DATA beat 2 -> all outputs zero next edge; a new start then runs a clean pass.
